sram_arbiter: RTL and testbench

// - Shares one external async 16-bit SRAM between the video fetch port (read-only) and the CPU port (read/write).
// - Sequences the SRAM pins: setup, strobe and hold phases; tristate data enable; read capture.
// - Sits between the top-level SRAM pins and the CPU/VGA datapath, which today has a constant-0 data input.

---
 rtl/sram_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 16-bit SRAM between a read-only video fetch port and a
// read/write CPU port. Each access runs SETUP (1 cycle), STROBE (ACCESS_CYCLES cycles) and, for
// writes only, HOLD (1 cycle), then returns to IDLE with a one-cycle ack pulse.
//
// Parameters:
//   AW             address width in 16-bit words
//   ACCESS_CYCLES  strobe length in clk cycles (>= 1); read data sampled on the last strobe cycle
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   vid_req/vid_addr            video read request (level) and word address, sampled at grant
//   vid_ack/vid_rdata           1-cycle completion pulse; last video read word (held)
//   cpu_req/cpu_we/cpu_addr/    CPU request (level), direction, address and write data,
//   cpu_wdata                   all sampled at grant
//   cpu_ack/cpu_rdata           1-cycle completion pulse; last CPU read word (held)
//   sram_addr/sram_d_out/       SRAM address, write data and data-pin drive enable
//   sram_d_oe
//   sram_d_in                   SRAM data pins, input side
//   sram_ce_n/oe_n/we_n         active-low SRAM strobes
//   busy                        1 while the sequencer is not in IDLE
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN  when defined, a tie between both ports goes to the port that was not
//                            granted last (first tie after reset goes to video). When undefined,
//                            video always wins a tie.
//
// All outputs are registers. No grant is issued in the cycle an ack is being presented, so the
// ack cycle doubles as a bus turnaround cycle and a requester still high afterwards is treated
// as a fresh request.

module sram_arbiter #(
  parameter int unsigned AW            = 14,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [15:0]   vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  output logic          cpu_ack,
  output logic [15:0]   cpu_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [15:0]   sram_d_out,
  output logic          sram_d_oe,
  input  logic [15:0]   sram_d_in,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          busy
);

  localparam int unsigned    CntW    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            owner_cpu_q, owner_cpu_d;
  logic            we_q, we_d;

  logic            vid_ack_q, vid_ack_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [15:0]     vid_rdata_q, vid_rdata_d;
  logic [15:0]     cpu_rdata_q, cpu_rdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     dout_q, dout_d;
  logic            doe_q, doe_d;
  logic            ce_n_q, ce_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            busy_q, busy_d;

  logic            ack_cycle;
  logic            grant_vid, grant_cpu;

  assign ack_cycle = vid_ack_q | cpu_ack_q;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_cpu_q, last_cpu_d;

  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == StIdle && !ack_cycle) begin
      if (vid_req && cpu_req) begin
        grant_vid = last_cpu_q;
        grant_cpu = !last_cpu_q;
      end else begin
        grant_vid = vid_req;
        grant_cpu = cpu_req;
      end
    end
  end

  always_comb begin
    last_cpu_d = last_cpu_q;
    if (grant_cpu) begin
      last_cpu_d = 1'b1;
    end else if (grant_vid) begin
      last_cpu_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cpu_q <= 1'b1;
    end else begin
      last_cpu_q <= last_cpu_d;
    end
  end
`else
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == StIdle && !ack_cycle) begin
      grant_vid = vid_req;
      grant_cpu = cpu_req && !vid_req;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_cpu_d = owner_cpu_q;
    we_d        = we_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    doe_d       = doe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    busy_d      = busy_q;

    unique case (state_q)
      StIdle: begin
        if (grant_vid || grant_cpu) begin
          state_d     = StSetup;
          owner_cpu_d = grant_cpu;
          we_d        = grant_cpu && cpu_we;
          addr_d      = grant_cpu ? cpu_addr : vid_addr;
          if (grant_cpu && cpu_we) begin
            dout_d = cpu_wdata;
          end
          doe_d  = grant_cpu && cpu_we;
          ce_n_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = CntLoad;
        if (we_q) begin
          we_n_d = 1'b0;
        end else begin
          oe_n_d = 1'b0;
        end
      end
      StStrobe: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (we_q) begin
          // Release we_n one cycle before address/data so the write latches cleanly.
          state_d = StHold;
          we_n_d  = 1'b1;
        end else begin
          state_d = StIdle;
          oe_n_d  = 1'b1;
          ce_n_d  = 1'b1;
          busy_d  = 1'b0;
          if (owner_cpu_q) begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = sram_d_in;
          end else begin
            vid_ack_d   = 1'b1;
            vid_rdata_d = sram_d_in;
          end
        end
      end
      StHold: begin
        state_d   = StIdle;
        doe_d     = 1'b0;
        ce_n_d    = 1'b1;
        busy_d    = 1'b0;
        cpu_ack_d = owner_cpu_q;
        vid_ack_d = !owner_cpu_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_cpu_q <= 1'b0;
      we_q        <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_cpu_q <= owner_cpu_d;
      we_q        <= we_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
    end
  end

  assign vid_ack    = vid_ack_q;
  assign vid_rdata  = vid_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign sram_addr  = addr_q;
  assign sram_d_out = dout_q;
  assign sram_d_oe  = doe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a transaction-level model predicts every output each cycle, plus
// directed scenarios with hand-computed latencies and data. A second instance is built with
// ACCESS_CYCLES=1.

module tb_sram_arbiter;

  localparam int AW = 14;
  localparam int AC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset     = 1'b1;
  logic          vid_req   = 1'b0;
  logic [AW-1:0] vid_addr  = '0;
  logic          cpu_req   = 1'b0;
  logic          cpu_we    = 1'b0;
  logic [AW-1:0] cpu_addr  = '0;
  logic [15:0]   cpu_wdata = '0;
  logic          vid_ack, cpu_ack, sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n, busy;
  logic [15:0]   vid_rdata, cpu_rdata, sram_d_out, sram_d_in;
  logic [AW-1:0] sram_addr;

  // Second instance, ACCESS_CYCLES=1
  logic          c1_vid_req = 1'b0;
  logic [AW-1:0] c1_vid_addr = '0;
  logic          c1_req   = 1'b0;
  logic          c1_we    = 1'b0;
  logic [AW-1:0] c1_addr  = '0;
  logic [15:0]   c1_wdata = '0;
  logic [15:0]   c1_d_in  = 16'hA5C3;
  logic          c1_vid_ack, c1_ack, c1_d_oe, c1_ce_n, c1_oe_n, c1_we_n, c1_busy;
  logic [15:0]   c1_vid_rdata, c1_rdata, c1_d_out;
  logic [AW-1:0] c1_sram_addr;

  sram_arbiter #(.AW(AW), .ACCESS_CYCLES(AC)) u_dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .sram_addr(sram_addr), .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe),
    .sram_d_in(sram_d_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .busy(busy)
  );

  sram_arbiter #(.AW(AW), .ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .vid_req(c1_vid_req), .vid_addr(c1_vid_addr), .vid_ack(c1_vid_ack),
    .vid_rdata(c1_vid_rdata),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
    .sram_addr(c1_sram_addr), .sram_d_out(c1_d_out), .sram_d_oe(c1_d_oe),
    .sram_d_in(c1_d_in), .sram_ce_n(c1_ce_n), .sram_oe_n(c1_oe_n),
    .sram_we_n(c1_we_n), .busy(c1_busy)
  );

  // SRAM device: stores on strobed writes; echo mode returns the address as data.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic        echo_mode = 1'b0;
  assign sram_d_in = echo_mode ? 16'(sram_addr) : sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_d_oe) sram_mem[sram_addr] <= sram_d_out;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // An access is a sequence of phases: phase 0 = setup, 1..AC = strobe, AC+1 = hold (writes).
  // The ack appears in the cycle after the last phase; no grant is made in an ack cycle.
  bit          mdl_valid = 0;
  bit          m_active = 0, m_write = 0, m_cpu = 0, last_cpu = 1, was_ack, pick_cpu, strobe;
  int          m_phase = 0, m_len = 0;
  logic [15:0] m_rval = '0;
  logic [15:0] model_mem [0:(1<<AW)-1];
  logic        e_vid_ack = 0, e_cpu_ack = 0, e_d_oe = 0, e_ce_n = 1, e_oe_n = 1, e_we_n = 1;
  logic        e_busy = 0;
  logic [15:0] e_vid_rdata = '0, e_cpu_rdata = '0, e_dout = '0;
  logic [AW-1:0] e_addr = '0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = 16'h0000;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_active = 0; last_cpu = 1;
        e_vid_ack = 0; e_cpu_ack = 0; e_vid_rdata = '0; e_cpu_rdata = '0;
        e_addr = '0; e_dout = '0;
      end else begin
        was_ack   = e_vid_ack | e_cpu_ack;
        e_vid_ack = 0;
        e_cpu_ack = 0;
        if (m_active) begin
          m_phase++;
          if (m_phase == m_len) begin
            m_active = 0;
            if (m_cpu) begin
              e_cpu_ack = 1;
              if (!m_write) e_cpu_rdata = m_rval;
            end else begin
              e_vid_ack   = 1;
              e_vid_rdata = m_rval;
            end
          end
        end else if (!was_ack && (vid_req || cpu_req)) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          pick_cpu = cpu_req && (!vid_req || !last_cpu);
`else
          pick_cpu = !vid_req;
`endif
          m_active = 1; m_phase = 0; m_cpu = pick_cpu; last_cpu = pick_cpu;
          m_write  = pick_cpu && cpu_we;
          m_len    = AC + (m_write ? 2 : 1);
          e_addr   = pick_cpu ? cpu_addr : vid_addr;
          if (m_write) begin
            e_dout = cpu_wdata;
            model_mem[e_addr] = cpu_wdata;
          end
          m_rval = echo_mode ? 16'(e_addr) : model_mem[e_addr];
        end
      end
      strobe    = m_active && m_phase >= 1 && m_phase <= AC;
      e_ce_n    = !m_active;
      e_busy    = m_active;
      e_d_oe    = m_active && m_write;
      e_oe_n    = !(strobe && !m_write);
      e_we_n    = !(strobe && m_write);
      mdl_valid = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_ack = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (mdl_valid) begin
        chk("vid_ack",    32'(vid_ack),    32'(e_vid_ack));
        chk("cpu_ack",    32'(cpu_ack),    32'(e_cpu_ack));
        chk("vid_rdata",  32'(vid_rdata),  32'(e_vid_rdata));
        chk("cpu_rdata",  32'(cpu_rdata),  32'(e_cpu_rdata));
        chk("sram_addr",  32'(sram_addr),  32'(e_addr));
        chk("sram_d_out", 32'(sram_d_out), 32'(e_dout));
        chk("sram_d_oe",  32'(sram_d_oe),  32'(e_d_oe));
        chk("sram_ce_n",  32'(sram_ce_n),  32'(e_ce_n));
        chk("sram_oe_n",  32'(sram_oe_n),  32'(e_oe_n));
        chk("sram_we_n",  32'(sram_we_n),  32'(e_we_n));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("bus_oe_we_both_low", 32'(!sram_oe_n && !sram_we_n), 32'(0));
        chk("d_oe_without_write", 32'(sram_d_oe && !(m_active && m_write)), 32'(0));
        chk("ack_consecutive", 32'(prev_ack && (vid_ack || cpu_ack)), 32'(0));
        chk("c1_bus_oe_we_both_low", 32'(!c1_oe_n && !c1_we_n), 32'(0));
        prev_ack = vid_ack || cpu_ack;
      end
    end
  end

  // Waits (bounded) for an ack, starting at the negedge where the request was driven.
  // sel: 0 = vid, 1 = cpu, 2 = second instance cpu. lat stays -1 on timeout.
  task automatic wait_ack(input int sel, input int budget, output int lat,
                          output int we_lo, output int oe_lo);
    int  start;
    int  n;
    bit  done;
    start = cyc; lat = -1; we_lo = 0; oe_lo = 0; n = 0; done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      if (sel == 2) begin
        if (!c1_we_n) we_lo++;
        if (!c1_oe_n) oe_lo++;
        done = c1_ack;
      end else begin
        if (!sram_we_n) we_lo++;
        if (!sram_oe_n) oe_lo++;
        done = (sel == 1) ? cpu_ack : vid_ack;
      end
      if (done) lat = cyc - start;
    end
  endtask

  int lat, we_lo, oe_lo, t0, last_ack_cyc, nv, nc;
  bit last_was_cpu;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    // Reset values
    chk("rst_vid_ack",   32'(vid_ack),    32'(0));
    chk("rst_cpu_ack",   32'(cpu_ack),    32'(0));
    chk("rst_vid_rdata", 32'(vid_rdata),  32'(0));
    chk("rst_cpu_rdata", 32'(cpu_rdata),  32'(0));
    chk("rst_addr",      32'(sram_addr),  32'(0));
    chk("rst_dout",      32'(sram_d_out), 32'(0));
    chk("rst_d_oe",      32'(sram_d_oe),  32'(0));
    chk("rst_ce_n",      32'(sram_ce_n),  32'(1));
    chk("rst_oe_n",      32'(sram_oe_n),  32'(1));
    chk("rst_we_n",      32'(sram_we_n),  32'(1));
    chk("rst_busy",      32'(busy),       32'(0));
    reset = 1'b0;
    @(negedge clk);

    // CPU write 0x3FFF <- 0xBEEF, then read it back
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h3FFF; cpu_wdata = 16'hBEEF;
    wait_ack(1, 20, lat, we_lo, oe_lo);
    chk("wr_latency", 32'(lat), 32'(5));
    chk("wr_we_low_cycles", 32'(we_lo), 32'(2));
    chk("wr_oe_low_cycles", 32'(oe_lo), 32'(0));
    cpu_req = 0; cpu_wdata = 16'h0000;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h3FFF;
    wait_ack(1, 20, lat, we_lo, oe_lo);
    chk("rd_latency", 32'(lat), 32'(4));
    chk("rd_oe_low_cycles", 32'(oe_lo), 32'(2));
    chk("rd_data", 32'(cpu_rdata), 32'h0000BEEF);
    cpu_req = 0;
    @(negedge clk);

    // Simultaneous requests: video first, CPU 5 cycles later
    echo_mode = 1;
    vid_req = 1; vid_addr = 14'h0123;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h2ABC;
    wait_ack(0, 20, lat, we_lo, oe_lo);
    chk("tie_vid_latency", 32'(lat), 32'(4));
    chk("tie_vid_rdata", 32'(vid_rdata), 32'h00000123);
    vid_req = 0;
    wait_ack(1, 20, lat, we_lo, oe_lo);
    chk("tie_cpu_after_vid", 32'(lat), 32'(5));
    chk("tie_cpu_rdata", 32'(cpu_rdata), 32'h00002ABC);
    cpu_req = 0;
    @(negedge clk);

    // Continuous video request with a competing CPU read
    vid_req = 1; vid_addr = 14'h0200;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0055;
    t0 = cyc; last_ack_cyc = -1; nv = 0; nc = 0; last_was_cpu = 1;
    for (int i = 1; i <= 39; i++) begin
      @(negedge clk);
      if (vid_ack || cpu_ack) begin
        if (last_ack_cyc >= 0) chk("stream_ack_period", 32'(cyc - last_ack_cyc), 32'(5));
        else chk("stream_first_ack", 32'(cyc - t0), 32'(4));
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        chk("rr_alternate", 32'(cpu_ack), 32'(!last_was_cpu));
`endif
        last_was_cpu = cpu_ack;
        last_ack_cyc = cyc;
        if (vid_ack) nv++;
        if (cpu_ack) nc++;
      end
    end
    vid_req = 0; cpu_req = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    chk("stream_vid_acks", 32'(nv), 32'(4));
    chk("stream_cpu_acks", 32'(nc), 32'(4));
`else
    chk("stream_vid_acks", 32'(nv), 32'(8));
    chk("stream_cpu_acks", 32'(nc), 32'(0));
`endif
    @(negedge clk);

    // Reset during write strobe
    echo_mode = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0010; cpu_wdata = 16'h1234;
    repeat (2) @(negedge clk);
    chk("abort_in_strobe_we_n", 32'(sram_we_n), 32'(0));
    reset = 1; cpu_req = 0;
    @(negedge clk);
    chk("abort_we_n",      32'(sram_we_n), 32'(1));
    chk("abort_d_oe",      32'(sram_d_oe), 32'(0));
    chk("abort_ce_n",      32'(sram_ce_n), 32'(1));
    chk("abort_busy",      32'(busy),      32'(0));
    chk("abort_cpu_ack",   32'(cpu_ack),   32'(0));
    chk("abort_cpu_rdata", 32'(cpu_rdata), 32'(0));
    reset = 0;
    nc = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack) nc++;
    end
    chk("abort_no_late_ack", 32'(nc), 32'(0));

    // ACCESS_CYCLES=1 instance, CPU read
    c1_req = 1; c1_we = 0; c1_addr = 14'h0007;
    wait_ack(2, 20, lat, we_lo, oe_lo);
    chk("ac1_latency", 32'(lat), 32'(3));
    chk("ac1_oe_low_cycles", 32'(oe_lo), 32'(1));
    chk("ac1_rdata", 32'(c1_rdata), 32'h0000A5C3);
    c1_req = 0;

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
